round_judge: RTL and testbench

Upstream round controller for the tug-of-war datapath. Runs each round: holds the lights off for a pseudo-random delay, then lights them. It arbitrates the two player pushbuttons and emits a one-cycle `winrnd` pulse with `right`, `tie` and a stable `leds_on`. These drive the scorer's state advance directly. It freezes when the scorer reports `Victory`.

---
 rtl/tow_pkg.sv | 31 +++
 rtl/pb_sync.sv | 41 ++++
 rtl/round_judge.sv | 174 +++++++++++++++++
 tb/tb_round_judge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tow_pkg
//  Purpose  : Shared tug-of-war definitions: round FSM state encoding and
//             the round-delay LFSR constants and step function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tow_pkg;

   // Round controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_LIGHT  = 3'd2,
      ST_DECIDE = 3'd3,
      ST_HOLD   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16)
   localparam int                  c_lfsr_w    = 16;
   localparam logic [c_lfsr_w-1:0] c_lfsr_taps = 16'hB400;

   // Shift toward the MSB; the feedback bit enters at bit 0.
   function automatic logic [c_lfsr_w-1:0] lfsr_next(input logic [c_lfsr_w-1:0] v);
      return {v[c_lfsr_w-2:0], ^(v & c_lfsr_taps)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pb_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pb_sync
//  Purpose  : Two-flop synchronizer for a raw pushbutton plus rising-edge
//             detect on the synchronized level.
//  Ports    : clk   - system clock
//             rst   - asynchronous active-high reset
//             pb    - raw asynchronous button input
//             level - synchronized button level
//             rise  - one-cycle pulse on a synchronized 0->1 transition
//  Revision : 1.0  initial release
// ============================================================================
module pb_sync (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic level,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;   // previous synchronized level, for edge detect

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= pb;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign level = r_s2;
   assign rise  = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/round_judge.sv
`default_nettype none
// ============================================================================
//  Module   : round_judge
//  Purpose  : Tug-of-war round controller. Holds the lights off for a
//             pseudo-random delay, lights them, arbitrates the two buttons
//             and emits a one-cycle winrnd pulse; freezes on victory.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             tick               - timebase enable for delay/light counters
//             pb_l, pb_r         - raw pushbuttons
//             victory            - game over from scorer
//             leds_on            - round lights (registered)
//             winrnd             - one-cycle round-decided pulse
//             right, tie         - round result, valid with winrnd
//  Revision : 1.0  initial release
// ============================================================================
module round_judge
   import tow_pkg::*;
#(
   parameter int          DLY_MIN   = 8,
   parameter int          DLY_W     = 4,
   parameter int          LIGHT_MAX = 64,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic pb_l,
   input  logic pb_r,
   input  logic victory,
   output logic leds_on,
   output logic winrnd,
   output logic right,
   output logic tie
);

   localparam int c_dly_cw = $clog2(DLY_MIN + (1 << DLY_W));
   localparam int c_lit_cw = $clog2(LIGHT_MAX + 1);

   logic                w_lvl_l;
   logic                w_lvl_r;
   logic                w_ev_l;
   logic                w_ev_r;
   logic                w_any_ev;
   logic                w_both_low;
   logic [c_dly_cw-1:0] w_dly_load;

   logic [c_lfsr_w-1:0] r_lfsr;
   state_t              r_state;
   logic [c_dly_cw-1:0] r_dly;
   logic [c_lit_cw-1:0] r_lit;
   logic                r_leds_on;
   logic                r_winrnd;
   logic                r_right;
   logic                r_tie;

   pb_sync u_sync_l (
      .clk   (clk),
      .rst   (rst),
      .pb    (pb_l),
      .level (w_lvl_l),
      .rise  (w_ev_l)
   );

   pb_sync u_sync_r (
      .clk   (clk),
      .rst   (rst),
      .pb    (pb_r),
      .level (w_lvl_r),
      .rise  (w_ev_r)
   );

   assign w_any_ev   = w_ev_l | w_ev_r;
   assign w_both_low = ~w_lvl_l & ~w_lvl_r;
   assign w_dly_load = c_dly_cw'(DLY_MIN) + c_dly_cw'(r_lfsr[DLY_W-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   // Round FSM. leds_on/right/tie are only written on transitions, so they
   // hold through DECIDE and keep the captured result afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_dly     <= '0;
         r_lit     <= '0;
         r_leds_on <= 1'b0;
         r_winrnd  <= 1'b0;
         r_right   <= 1'b0;
         r_tie     <= 1'b0;
      end else begin
         r_winrnd <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (victory) begin
                  r_state <= ST_DONE;
               end else if (w_both_low) begin
                  r_state <= ST_WAIT;
                  r_dly   <= w_dly_load;
               end
            end
            ST_WAIT: begin
               // An edge beats a coincident expiry tick: scored as a jump.
               if (victory) begin
                  r_state <= ST_DONE;
               end else if (w_any_ev) begin
                  r_state  <= ST_DECIDE;
                  r_winrnd <= 1'b1;
                  r_right  <= w_ev_r & ~w_ev_l;
                  r_tie    <= w_ev_l & w_ev_r;
               end else if (tick) begin
                  if (r_dly <= c_dly_cw'(1)) begin
                     r_state   <= ST_LIGHT;
                     r_leds_on <= 1'b1;
                     r_lit     <= c_lit_cw'(LIGHT_MAX);
                  end else begin
                     r_dly <= r_dly - c_dly_cw'(1);
                  end
               end
            end
            ST_LIGHT: begin
               if (victory) begin
                  r_state   <= ST_DONE;
                  r_leds_on <= 1'b0;
               end else if (w_any_ev) begin
                  r_state  <= ST_DECIDE;
                  r_winrnd <= 1'b1;
                  r_right  <= w_ev_r & ~w_ev_l;
                  r_tie    <= w_ev_l & w_ev_r;
               end else if (tick) begin
                  if (r_lit <= c_lit_cw'(1)) begin
                     r_state   <= ST_IDLE;
                     r_leds_on <= 1'b0;
                  end else begin
                     r_lit <= r_lit - c_lit_cw'(1);
                  end
               end
            end
            ST_DECIDE: begin
               // The pulse always completes before victory freezes us.
               r_leds_on <= 1'b0;
               r_state   <= victory ? ST_DONE : ST_HOLD;
            end
            ST_HOLD: begin
               if (victory) begin
                  r_state <= ST_DONE;
               end else if (tick && w_both_low) begin
                  r_state <= ST_WAIT;
                  r_dly   <= w_dly_load;
               end
            end
            ST_DONE: begin
               r_state   <= ST_DONE;
               r_leds_on <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_leds_on <= 1'b0;
            end
         endcase
      end
   end

   assign leds_on = r_leds_on;
   assign winrnd  = r_winrnd;
   assign right   = r_right;
   assign tie     = r_tie;

endmodule
`default_nettype wire

// File: tb/tb_round_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_judge
//  Purpose  : Self-checking bench for round_judge. Rounds are planned as
//             events (WAIT entry edge, lights-on edge, capture edge) from
//             the round rules; every cycle's leds_on/winrnd is compared.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_round_judge;

   localparam int          P_DLY_MIN   = 4;
   localparam int          P_DLY_W     = 2;
   localparam int          P_LIGHT_MAX = 10;
   localparam logic [15:0] P_SEED      = 16'hACE1;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic tick    = 1'b1;
   logic pb_l    = 1'b0;
   logic pb_r    = 1'b0;
   logic victory = 1'b0;
   logic leds_on;
   logic winrnd;
   logic right;
   logic tie;

   int n_checks = 0;
   int n_errors = 0;
   int n        = 0;   // clock edges since reset release
   int m        = 1;   // edge at which the next WAIT is entered

   always #5 clk = ~clk;

   round_judge #(
      .DLY_MIN   (P_DLY_MIN),
      .DLY_W     (P_DLY_W),
      .LIGHT_MAX (P_LIGHT_MAX),
      .SEED      (P_SEED)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pb_l    (pb_l),
      .pb_r    (pb_r),
      .victory (victory),
      .leds_on (leds_on),
      .winrnd  (winrnd),
      .right   (right),
      .tie     (tie)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   // Lights-off delay for a WAIT entered at edge (steps+1): the LFSR has
   // advanced 'steps' times since reset when the delay is loaded.
   function automatic int delay_for(input int steps);
      logic [15:0] v;
      v = P_SEED;
      for (int i = 0; i < steps; i++) begin
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      end
      return P_DLY_MIN + int'(v[P_DLY_W-1:0]);
   endfunction

   // One clock; outputs checked at the following falling edge.
   task automatic cyc(input bit exp_leds, input bit exp_win, input bit exp_right, input bit exp_tie);
      @(posedge clk);
      n++;
      @(negedge clk);
      check_val("leds_on", leds_on, exp_leds);
      check_val("winrnd", winrnd, exp_win);
      if (exp_win) begin
         check_val("right", right, exp_right);
         check_val("tie", tie, exp_tie);
      end
   endtask

   // kind: 0 jump at random point, 1/2 press while lit, 3 timeout,
   //       4 jump exactly on the expiring tick.
   // who : 1 left, 2 right, 3 both. hold: extra cycles button kept high.
   task automatic run_round(input int kind, input int who, input int hold);
      int  d;
      int  lt;
      int  c;
      int  last;
      int  k;
      bit  lit;
      d   = delay_for(m - 1);
      lt  = m + d;                    // first edge after which lights are on
      lit = (kind == 1 || kind == 2 || kind == 3);
      if (kind == 0)      c = $urandom_range(m + d, m + 3);
      else if (kind == 4) c = m + d;
      else if (kind == 3) c = -1;
      else                c = $urandom_range(lt + P_LIGHT_MAX - 1, lt + 1);
      last = (kind == 3) ? lt + P_LIGHT_MAX : c + hold;
      while (n < last) begin
         k = n + 1;
         if (c > 0 && n == c - 3) begin
            pb_l = who[0];
            pb_r = who[1];
         end
         cyc(lit && k >= lt && ((kind == 3) ? (k < lt + P_LIGHT_MAX) : (k <= c)),
             k == c, who == 2, who == 3);
      end
      pb_l = 1'b0;
      pb_r = 1'b0;
      // Timeout returns through IDLE; otherwise HOLD sees release 2 edges late.
      m = (kind == 3) ? lt + P_LIGHT_MAX + 1 : last + 3;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_leds_on", leds_on, 1'b0);
      check_val("rst_winrnd", winrnd, 1'b0);
      check_val("rst_right", right, 1'b0);
      check_val("rst_tie", tie, 1'b0);
      rst = 1'b0;
      n   = 0;
      m   = 1;

      // Directed rounds
      run_round(1, 2, 0);   // proper right push
      run_round(0, 1, 0);   // left jumps the light
      run_round(2, 3, 0);   // tie while lit
      run_round(1, 2, 6);   // held right button through HOLD
      run_round(3, 0, 0);   // timeout
      run_round(4, 1, 1);   // jump on the expiring tick

      // Random rounds
      for (int i = 0; i < 30; i++) begin
         run_round($urandom_range(4, 0), $urandom_range(3, 1), $urandom_range(4, 0));
      end

      // Victory during WAIT freezes the judge
      while (n < m) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      victory = 1'b1;
      for (int i = 0; i < 30; i++) begin
         pb_l = 1'($urandom_range(1, 0));
         pb_r = 1'($urandom_range(1, 0));
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      victory = 1'b0;
      pb_l    = 1'b0;
      pb_r    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            pb_r = 1'b1;
         end
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      pb_r = 1'b0;

      // Reset out of DONE clears every output without a clock edge
      #2 rst = 1'b1;
      #1;
      check_val("rst_done_leds_on", leds_on, 1'b0);
      check_val("rst_done_winrnd", winrnd, 1'b0);
      check_val("rst_done_right", right, 1'b0);
      check_val("rst_done_tie", tie, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      m   = 1;

      // Run into LIGHT, then reset mid-round
      begin
         int lt;
         lt = m + delay_for(m - 1);
         while (n < lt + 3) cyc(n + 1 >= lt, 1'b0, 1'b0, 1'b0);
      end
      #2 rst = 1'b1;
      #1;
      check_val("rst_light_leds_on", leds_on, 1'b0);
      check_val("rst_light_winrnd", winrnd, 1'b0);
      repeat (2) @(negedge clk);
      check_val("rst_hold_leds_on", leds_on, 1'b0);
      rst = 1'b0;
      n   = 0;
      m   = 1;
      run_round(1, 2, 0);   // restarts from IDLE with the seed delay

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
